// File: rtl/core_pkg.sv
// Shared definitions for the pipelined ARM core: data widths, the PC step,
// the bubble encoding and the IF/ID pipeline register payload.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'hE1A0_0000;  // MOV r0,r0

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding an if_id_t with bubble / load / hold control.
// bubble beats load; neither asserted means hold. Reset loads a bubble.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t data_i,
  output if_id_t data_o
);

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

  if_id_t data_q;
  if_id_t data_d;

  always_comb begin
    data_d = data_q;
    if (bubble) begin
      data_d = BUBBLE;
    end else if (load) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= BUBBLE;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and the IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            flush_d,
  input  logic            branch_taken_e,
  input  logic [XLEN-1:0] branch_target_e,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus8_d,
  output logic            valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_stalls,
  output logic [XLEN-1:0] perf_flushes
`endif
);

  logic [XLEN-1:0] pc_f_q;
  logic [XLEN-1:0] pc_f_d;
  logic            if_id_bubble;
  logic            if_id_load;
  if_id_t          if_id_in;
  if_id_t          if_id_out;

  // A redirect overrides stall so the wrong-path fetch is never held.
  always_comb begin
    pc_f_d = pc_f_q + PC_STEP;
    if (branch_taken_e) begin
      pc_f_d = {branch_target_e[XLEN-1:2], 2'b00};
    end else if (stall_f) begin
      pc_f_d = pc_f_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q <= RESET_PC;
    end else begin
      pc_f_q <= pc_f_d;
    end
  end

  assign if_id_bubble = branch_taken_e | flush_d;
  assign if_id_load   = ~stall_f;
  assign if_id_in     = '{instr: imem_rd, pc: pc_f_q, valid: 1'b1};

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (if_id_load),
    .bubble(if_id_bubble),
    .data_i(if_id_in),
    .data_o(if_id_out)
  );

  assign imem_addr  = pc_f_q;
  assign instr_d    = if_id_out.instr;
  assign pc_d       = if_id_out.pc;
  assign valid_d    = if_id_out.valid;
  assign pc_plus8_d = if_id_out.pc + 32'd8;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetched_q, fetched_d;
  logic [XLEN-1:0] stalls_q, stalls_d;
  logic [XLEN-1:0] flushes_q, flushes_d;

  always_comb begin
    fetched_d = fetched_q;
    stalls_d  = stalls_q;
    flushes_d = flushes_q;
    if (!if_id_bubble && if_id_load) begin
      fetched_d = sat_inc(fetched_q);
    end
    if (stall_f && !branch_taken_e) begin
      stalls_d = sat_inc(stalls_q);
    end
    if (if_id_bubble) begin
      flushes_d = sat_inc(flushes_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
  assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns addr + 0x100.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        flush_d;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus8_d;
  logic        valid_d;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rd = imem_addr + 32'h100;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .flush_d        (flush_d),
    .branch_taken_e (branch_taken_e),
    .branch_target_e(branch_target_e),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus8_d     (pc_plus8_d),
    .valid_d        (valid_d)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stalls    (perf_stalls),
    .perf_flushes   (perf_flushes)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] t);
    stall_f = s;
    flush_d = f;
    branch_taken_e = b;
    branch_target_e = t;
  endtask

  // Compare full observable state after one edge against expected values.
  task automatic expect_state(input string name, input logic [31:0] e_addr,
                              input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic e_valid);
    checks++;
    if (imem_addr !== e_addr || instr_d !== e_instr || pc_d !== e_pc ||
        valid_d !== e_valid || pc_plus8_d !== e_pc + 32'd8) begin
      errors++;
      $display("FAIL %s: got addr=%h instr=%h pc=%h p8=%h v=%b, expected addr=%h instr=%h pc=%h p8=%h v=%b",
               name, imem_addr, instr_d, pc_d, pc_plus8_d, valid_d,
               e_addr, e_instr, e_pc, e_pc + 32'd8, e_valid);
    end else begin
      $display("ok   %s: addr=%h instr=%h pc=%h p8=%h v=%b",
               name, imem_addr, instr_d, pc_d, pc_plus8_d, valid_d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    expect_state("reset", 32'h0, NOP, 32'h0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] e_addr [2] = '{32'h4, 32'h8};
    logic [31:0] e_ins  [2] = '{32'h100, 32'h104};
    logic [31:0] e_pc   [2] = '{32'h0, 32'h4};
    for (int i = 0; i < 2; i++) begin
      step();
      expect_state("free_run", e_addr[i], e_ins[i], e_pc[i], 1'b1);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      expect_state("stall_hold", 32'h8, 32'h104, 32'h4, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    expect_state("stall_release", 32'hC, 32'h108, 32'h8, 1'b1);
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    expect_state("flush", 32'h10, NOP, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    expect_state("after_flush", 32'h14, 32'h110, 32'h10, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    expect_state("flush_stall", 32'h14, NOP, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    expect_state("after_flush_stall", 32'h18, 32'h114, 32'h14, 1'b1);
  endtask

  task automatic test_branch();
    drive(1'b1, 1'b0, 1'b1, 32'h40);
    step();
    expect_state("branch_stall", 32'h40, NOP, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    expect_state("branch_target", 32'h44, 32'h140, 32'h40, 1'b1);
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    step();
    expect_state("wrap_redirect", 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    expect_state("wrap_top", 32'h0, 32'h0000_00FC, 32'hFFFF_FFFC, 1'b1);
    step();
    expect_state("wrap_zero", 32'h4, 32'h100, 32'h0, 1'b1);
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h20);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    expect_state("pre_reset", 32'h24, 32'h120, 32'h20, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h80);
    step();
    expect_state("mid_reset", 32'h0, NOP, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_fetched !== 32'h0 || perf_stalls !== 32'h0 || perf_flushes !== 32'h0) begin
      errors++;
      $display("FAIL perf_reset: got %0d/%0d/%0d, expected 0/0/0",
               perf_fetched, perf_stalls, perf_flushes);
    end else begin
      $display("ok   perf_reset: counters cleared");
    end
`endif
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    expect_state("after_reset", 32'h4, 32'h100, 32'h0, 1'b1);
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    step();                              // fetch
    step();                              // fetch
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();                              // stall
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();                              // flush
    drive(1'b1, 1'b0, 1'b1, 32'h40);
    step();                              // redirect with stall
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (perf_fetched !== 32'd2 || perf_stalls !== 32'd1 || perf_flushes !== 32'd2) begin
      errors++;
      $display("FAIL perf_counts: got %0d/%0d/%0d, expected 2/1/2",
               perf_fetched, perf_stalls, perf_flushes);
    end else begin
      $display("ok   perf_counts: fetched=2 stalls=1 flushes=2");
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_free_run();
    test_stall();
    test_flush();
    test_branch();
    test_wrap();
    test_mid_reset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage for the pipelined ARM core. It feeds the decode stage and the register file that sits directly downstream.
- Owns the PC and drives the instruction-memory address.
- Registers the fetched word into the IF/ID pipeline register.
- Honours stall, flush and taken-branch redirect from downstream hazard and execute logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'hE1A0_0000, bubble encoding (MOV r0,r0) inserted into IF/ID on reset and flush

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall_f  in  1  hold PC and IF/ID contents this cycle
flush_d  in  1  replace IF/ID contents with bubble this cycle
branch_taken_e  in  1  redirect fetch to branch_target_e
branch_target_e  in  32  redirect address from execute
imem_addr  out  32  instruction memory address (combinational = pc_f)
imem_rd  in  32  instruction word, combinational read of imem_addr
instr_d  out  32  registered instruction for decode
pc_d  out  32  registered address of instr_d
pc_plus8_d  out  32  pc_d + 8 (ARM PC-read value), combinational from pc_d
valid_d  out  1  instr_d is a real fetched instruction, not a bubble

Behaviour:
- Reset (rst=1 at posedge): pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, valid_d=0. imem_addr=RESET_PC from the next cycle. Reset overrides all other inputs. Reset mid-stream discards in-flight IF/ID contents.
- No FSM. State is pc_f plus the IF/ID register {instr, pc, valid}.
- Per-edge priority, highest first:
  1. rst.
  2. branch_taken_e: pc_f <= {branch_target_e[31:2],2'b00}; IF/ID <= bubble. Overrides stall_f and flush_d.
  3. IF/ID update: flush_d forces IF/ID <= bubble; otherwise stall_f holds IF/ID; otherwise IF/ID <= {imem_rd, pc_f, 1}.
  4. pc_f update: stall_f holds pc_f; otherwise pc_f <= pc_f + 4.
- flush_d with stall_f: IF/ID becomes a bubble and pc_f holds. This is the load-use-plus-branch case.
- Bubble = {NOP_INSTR, pc 0, valid 0}.
- Latency: word at address A appears on instr_d the cycle after pc_f==A.
- Throughput: one instruction per cycle when unstalled.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0, with no flag.
- pc_plus8_d wraps modulo 2^32.
- Branch targets with nonzero low bits are silently word-aligned.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetched[31:0], perf_stalls[31:0] and perf_flushes[31:0].
  - perf_fetched counts edges where IF/ID loads valid=1.
  - perf_stalls counts edges with stall_f=1 and no redirect.
  - perf_flushes counts edges that load a bubble due to flush_d or branch_taken_e.
  - All counters clear on rst and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared package (core_pkg):
  - XLEN=32 and PC_STEP=4.
  - NOP_INSTR default value.
  - Typedef if_id_t struct {instr, pc, valid}.
- One sub-module: if_id_reg.
  - Holds an if_id_t with load/hold/bubble controls and synchronous reset.
  - The pipeline reuses it pattern-wise for later stages.
- fetch_stage contains the PC register, next-PC mux and the if_id_reg instance.

Test Plan:
- Reset then 4 free-running cycles with imem returning addr+32'h100 → imem_addr 0,4,8,C. instr_d 0x100,0x104,0x108 with pc_d 0,4,8. pc_plus8_d 8,C,10. valid_d 0 in the first cycle after reset.
- stall_f=1 for 2 cycles at pc_f=8 → imem_addr stays 8. instr_d/pc_d hold at 0x104/4. Resumes 0x108 after release, with no skipped or duplicated address.
- branch_taken_e=1, target 32'h40, together with stall_f=1 → next imem_addr=0x40. instr_d=NOP_INSTR, valid_d=0. The cycle after, instr_d=mem[0x40], pc_d=0x40.
- flush_d=1 alone at pc_f=C → instr_d=NOP_INSTR, valid_d=0, imem_addr advances to 0x10.
- Redirect to 32'hFFFF_FFFE → pc_f=FFFF_FFFC, then wraps to 0. pc_plus8_d of FFFF_FFFC = 4.
- rst asserted mid-stream at pc_f=0x20 → next cycle pc_f=RESET_PC, valid_d=0, instr_d=NOP_INSTR. With FETCH_PERF_EN, all counters read 0.
